// File: rtl/pkt_sender_pkg.sv
// Shared flit definitions for the packet sender: type codes, field widths
// and the FSM state encoding.
package pkt_sender_pkg;

    localparam int PORTW = 4;
    localparam int LENW  = 4;
    localparam int DW    = 8;
    localparam int PKTW  = 9;          // msb index of a flit
    localparam int FLITW = PKTW + 1;   // flit width in bits

    // Flit type lives in the top two bits of every flit.
    typedef enum logic [1:0] {
        FT_IDLE = 2'b00,
        FT_HEAD = 2'b10,
        FT_BODY = 2'b01,
        FT_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_e;

    // Head flit: type, destination port, source port.
    function automatic logic [FLITW-1:0] make_head(input logic [PORTW-1:0] dst,
                                                  input logic [PORTW-1:0] src);
        return {FT_HEAD, dst, src};
    endfunction

endpackage

// File: rtl/pkt_sender.sv
// Packet framer: turns a descriptor plus payload words into head/body/tail
// flits on a registered fifo write port, honouring the fifo full flag.
//
// Handshakes: an input transfers on the clock edge where its valid and
// ready are both high. Ready never depends on valid. On the output side a
// flit transfers on the edge where we is high and full is low; while
// we & full the output register holds pkto/we unchanged.
module pkt_sender
    import pkt_sender_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             d_valid,
    output logic             d_ready,
    input  logic [PORTW-1:0] d_dst,
    input  logic [PORTW-1:0] d_src,
    input  logic [LENW-1:0]  d_len,
    input  logic [DW-1:0]    din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [PKTW:0]    pkto,
    output logic             we,
    input  logic             full,
    output logic             busy,
    output logic             err
);

    state_e          state;
    logic [LENW-1:0] cnt;   // flits still to load after the current one
    logic            slot_free;
    logic            d_take;
    logic            w_take;
    logic            short_len;
    logic            last_word;

    // The output register can accept a new flit when it is empty or when
    // its current flit leaves on this edge.
    always_comb begin
        slot_free = !we || !full;
        d_ready   = !rst && (state == ST_IDLE) && slot_free;
        din_ready = !rst && (state == ST_DATA) && slot_free;
        d_take    = d_valid && d_ready;
        w_take    = din_valid && din_ready;
        short_len = (d_len < LENW'(2));
        last_word = (cnt == LENW'(1));
        busy      = (state != ST_IDLE);
    end

    // FSM, payload down-counter and the registered flit output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pkto  <= '0;
            we    <= 1'b0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            // Register drained with nothing new to load: emit a bubble.
            if (slot_free) begin
                we   <= 1'b0;
                pkto <= '0;
            end
            case (state)
                ST_IDLE: begin
                    if (d_take) begin
                        pkto  <= make_head(d_dst, d_src);
                        we    <= 1'b1;
                        // Short descriptors still go out as head + tail.
                        cnt   <= short_len ? LENW'(1) : d_len - LENW'(1);
                        err   <= short_len;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_take) begin
                        pkto <= {(last_word ? FT_TAIL : FT_BODY), din};
                        we   <= 1'b1;
                        cnt  <= cnt - LENW'(1);
                        if (last_word) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_sender.sv
// Directed bench for pkt_sender: reset, plain packets, fifo backpressure,
// back-to-back packets, short-length error, mid-packet reset and payload gaps.
module tb_pkt_sender;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_valid;
    logic       d_ready;
    logic [3:0] d_dst;
    logic [3:0] d_src;
    logic [3:0] d_len;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [9:0] pkto;
    logic       we;
    logic       full;
    logic       busy;
    logic       err;

    int total = 0;
    int bad   = 0;

    pkt_sender dut (
        .clk       (clk),
        .rst       (rst),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_dst     (d_dst),
        .d_src     (d_src),
        .d_len     (d_len),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .pkto      (pkto),
        .we        (we),
        .full      (full),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are looked at 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expect a valid flit in the output register.
    task automatic chk_flit(input string tag, input logic [9:0] exp);
        chk(tag, {5'd0, we, pkto}, {5'd0, 1'b1, exp});
    endtask

    // Expect an empty output register.
    task automatic chk_idle(input string tag);
        chk(tag, {5'd0, we, pkto}, 16'd0);
    endtask

    task automatic desc(input logic [3:0] dst, input logic [3:0] src, input logic [3:0] len);
        d_valid = 1'b1;
        d_dst   = dst;
        d_src   = src;
        d_len   = len;
    endtask

    initial begin
        rst = 1'b1; d_valid = 1'b0; d_dst = '0; d_src = '0; d_len = '0;
        din = '0; din_valid = 1'b0; full = 1'b0;

        // 1: reset
        tick(); tick();
        chk("rst_dready_low", {15'd0, d_ready}, 16'd0);
        chk("rst_dinready_low", {15'd0, din_ready}, 16'd0);
        rst = 1'b0;
        #1;
        chk_idle("rst_out");
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_dready", {15'd0, d_ready}, 16'd1);

        // 2: len 4 packet, no backpressure
        desc(4'd1, 4'd9, 4'd4);
        tick();
        chk_flit("p2_head", 10'b10_0001_1001);
        chk("p2_busy", {15'd0, busy}, 16'd1);
        d_valid = 1'b0; din_valid = 1'b1; din = 8'h00;
        chk("p2_dinready", {15'd0, din_ready}, 16'd1);
        tick(); chk_flit("p2_body0", 10'b01_0000_0000);
        din = 8'h01;
        tick(); chk_flit("p2_body1", 10'b01_0000_0001);
        din = 8'h02;
        tick(); chk_flit("p2_tail", 10'b11_0000_0010);
        chk("p2_busy_end", {15'd0, busy}, 16'd0);
        din_valid = 1'b0;
        tick(); chk_idle("p2_idle");

        // 3: backpressure after body0
        desc(4'd1, 4'd9, 4'd4);
        tick(); chk_flit("p3_head", 10'h219);
        d_valid = 1'b0; din_valid = 1'b1; din = 8'h00;
        tick(); chk_flit("p3_body0", 10'h100);
        full = 1'b1; din = 8'h01;
        #1;
        chk("p3_hold_ready0", {15'd0, din_ready}, 16'd0);
        tick(); chk_flit("p3_hold1", 10'h100);
        tick(); chk_flit("p3_hold2", 10'h100);
        tick(); chk_flit("p3_hold3", 10'h100);
        chk("p3_hold_ready", {15'd0, din_ready}, 16'd0);
        full = 1'b0;
        #1;
        chk("p3_resume_ready", {15'd0, din_ready}, 16'd1);
        tick(); chk_flit("p3_body1", 10'h101);
        din = 8'h02;
        tick(); chk_flit("p3_tail", 10'h302);
        din_valid = 1'b0;
        tick(); chk_idle("p3_idle");

        // 4: back-to-back len 3 packets
        desc(4'd2, 4'd3, 4'd3);
        tick(); chk_flit("p4_head_a", 10'h223);
        d_valid = 1'b0; din_valid = 1'b1; din = 8'hA0;
        tick(); chk_flit("p4_body_a", 10'h1A0);
        din = 8'hA1;
        tick(); chk_flit("p4_tail_a", 10'h3A1);
        din_valid = 1'b0;
        desc(4'd4, 4'd5, 4'd3);
        #1;
        chk("p4_dready_at_tail", {15'd0, d_ready}, 16'd1);
        tick(); chk_flit("p4_head_b", 10'h245);
        d_valid = 1'b0; din_valid = 1'b1; din = 8'hB0;
        tick(); chk_flit("p4_body_b", 10'h1B0);
        din = 8'hB1;
        tick(); chk_flit("p4_tail_b", 10'h3B1);
        din_valid = 1'b0;
        tick(); chk_idle("p4_idle");

        // 5: len 1 -> err pulse, head + tail
        desc(4'd6, 4'd7, 4'd1);
        tick(); chk_flit("p5_head", 10'h267);
        chk("p5_err", {15'd0, err}, 16'd1);
        d_valid = 1'b0; din_valid = 1'b1; din = 8'h55;
        tick(); chk_flit("p5_tail", 10'h355);
        chk("p5_err_clr", {15'd0, err}, 16'd0);
        chk("p5_busy", {15'd0, busy}, 16'd0);
        din_valid = 1'b0;
        tick(); chk_idle("p5_idle");

        // 6: reset mid-packet, then a clean packet
        desc(4'd1, 4'd2, 4'd4);
        tick(); chk_flit("p6_head", 10'h212);
        d_valid = 1'b0; din_valid = 1'b1; din = 8'h10;
        tick(); chk_flit("p6_body0", 10'h110);
        rst = 1'b1;
        #1;
        chk("p6_rst_dinready", {15'd0, din_ready}, 16'd0);
        tick(); chk_idle("p6_rst_out");
        chk("p6_rst_busy", {15'd0, busy}, 16'd0);
        rst = 1'b0; din_valid = 1'b0;
        desc(4'd3, 4'd4, 4'd2);
        tick(); chk_flit("p6_new_head", 10'h234);
        d_valid = 1'b0; din_valid = 1'b1; din = 8'h77;
        tick(); chk_flit("p6_new_tail", 10'h377);
        din_valid = 1'b0;
        tick(); chk_idle("p6_new_idle");

        // 7: payload gap of two cycles; descriptor offered during DATA is ignored
        desc(4'd5, 4'd6, 4'd4);
        tick(); chk_flit("p7_head", 10'h256);
        d_valid = 1'b0; din_valid = 1'b1; din = 8'h20;
        tick(); chk_flit("p7_body0", 10'h120);
        din_valid = 1'b0;
        desc(4'd15, 4'd15, 4'd2);
        tick(); chk_idle("p7_gap1");
        chk("p7_dready_data", {15'd0, d_ready}, 16'd0);
        tick(); chk_idle("p7_gap2");
        chk("p7_busy_gap", {15'd0, busy}, 16'd1);
        d_valid = 1'b0; din_valid = 1'b1; din = 8'h21;
        tick(); chk_flit("p7_body1", 10'h121);
        din = 8'h22;
        tick(); chk_flit("p7_tail", 10'h322);
        din_valid = 1'b0;
        tick(); chk_idle("p7_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
